serial_add_sched: RTL
=====================

# serial_add_sched

Round-robin scheduler and sequencer for the shared bit-serial adder datapath (operand shift registers, 1-bit full adder, carry flip-flop, sum shift register). Two requesters submit operand pairs over a req/done handshake. The block grants one requester at a time, loads its operands, clocks the serial datapath for exactly WIDTH bit-cycles and returns the WIDTH+1-bit result. It sits between the client logic and the serial adder and owns all of the adder's load, enable and carry-clear sequencing.

## Interface
- WIDTH, 8, operand width in bits (≥2).
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- req  input  2  per-requester request; bit i belongs to requester i.
- a0, b0  input  WIDTH  requester 0 operands.
- a1, b1  input  WIDTH  requester 1 operands.
- sub  input  2  per-requester subtract select; present only with SA_SUB_EN.
- gnt  output  2  one-hot grant, high from LOAD through DONE.
- done  output  2  one-cycle completion pulse to the granted requester.
- sum  output  WIDTH+1  result register; bit WIDTH is the final carry.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- Internal resources:
  - operand shift registers sa, sb (WIDTH);
  - carry FF c;
  - sum shift register s (WIDTH);
  - bit counter cnt (clog2(WIDTH+1));
  - round-robin pointer rr (1 bit; the requester preferred next).
- IDLE:
  - If no req bit is set, stay in IDLE.
  - If only one req bit is set, grant that requester.
  - If both are set, grant requester rr.
  - On a grant: register gnt, set rr to the other requester, go to LOAD.
- LOAD (1 cycle):
  - sa ← a of the granted requester; sb ← b of the granted requester.
  - c ← 0; cnt ← 0; s ← 0.
  - Go to SHIFT.
- SHIFT (WIDTH cycles):
  - Compute bit = sa[0]^sb[0]^c.
  - c ← majority(sa[0], sb[0], c).
  - s ← {bit, s[WIDTH-1:1]}.
  - sa and sb shift right with 0 fill.
  - cnt increments each cycle.
  - When cnt = WIDTH-1, go to DONE.
- DONE (1 cycle):
  - sum ← {c, s}, with the register loaded on entry to DONE.
  - done[i] = 1 for the granted requester.
  - gnt is cleared on exit; go to IDLE.
- Handshake:
  - The requester holds req and operands until done.
  - Operands are sampled only in LOAD; later changes are ignored.
  - The requester must deassert req in the cycle after done, or it is re-arbitrated as a new request.
- req dropped before done: the operation still completes and done still pulses.
- Arithmetic: sum = a + b, zero-extended to WIDTH+1 bits, and never overflows.
- sum holds its value from DONE until the next DONE. Only the s/sa/sb internals change during SHIFT.

## Timing
- Request sampled in IDLE at edge 0:
  - gnt high after edge 0;
  - LOAD during cycle 1;
  - SHIFT during cycles 2..WIDTH+1;
  - done and sum valid after edge WIDTH+1, during cycle WIDTH+2.
- Throughput: one operation per WIDTH+3 cycles. The next grant occurs at the earliest in the cycle after DONE.
- Reset values (async, immediate):
  - state = IDLE, gnt = 0, done = 0, sum = 0, busy = 0;
  - rr = 0 (requester 0 is preferred first);
  - c, cnt, sa, sb and s all 0.
- Reset asserted mid-operation: the operation is aborted with no done pulse, and the result is lost.
- Arbitration is evaluated only in IDLE. Requests arriving while busy wait; there is no preemption.
- Both requests held continuously: grants alternate 0,1,0,1,…

## Configuration
- SA_SUB_EN defined:
  - Port sub[1:0] exists.
  - When the granted requester's sub bit is 1 in LOAD:
    - sb loads ~b;
    - c loads 1;
    - sum = a − b as WIDTH bits plus sum[WIDTH] = no-borrow flag (1 when a ≥ b).
  - sub is sampled only in LOAD.
- SA_SUB_EN undefined:
  - No sub port.
  - Addition only; c is always cleared in LOAD.

## Test plan
- WIDTH=8, req=01, a0=0x5A, b0=0x33 → gnt=01 one cycle later; done=01 exactly 10 cycles after the req sample; sum=0x08D.
- req=10, a1=0xFF, b1=0xFF → done=10; sum=0x1FE; busy high for exactly 10 cycles.
- req=11 held after reset → first grant to requester 0, then requester 1, then requester 0 again; each done pulses exactly once per grant.
- a0 changed to 0x00 during SHIFT, and req0 dropped during SHIFT, with a0=0x01, b0=0x01 at LOAD → sum=0x002; done still pulses; no re-grant follows.
- resetn pulsed low at SHIFT cycle 4 → all outputs 0 immediately; no done pulse; the next request completes correctly, with rr = 0.
- SA_SUB_EN: sub=01, a0=0x10, b0=0x20 → sum=0x0F0 (bit 8 = 0); with a0=0x20, b0=0x10 → sum=0x110.

Source files
------------

// File: rtl/serial_add_sched_if.sv
// Client-side bundle for serial_add_sched: requests, operands, grant/done and result.
// The sub port exists only when SA_SUB_EN is defined.
interface serial_add_sched_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] a0, b0, a1, b1;
`ifdef SA_SUB_EN
  logic [1:0]       sub;
`endif
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH:0]   sum;
  logic             busy;

`ifdef SA_SUB_EN
  modport master (output req, a0, b0, a1, b1, sub, input gnt, done, sum, busy);
  modport slave  (input req, a0, b0, a1, b1, sub, output gnt, done, sum, busy);
`else
  modport master (output req, a0, b0, a1, b1, input gnt, done, sum, busy);
  modport slave  (input req, a0, b0, a1, b1, output gnt, done, sum, busy);
`endif
endinterface

// File: rtl/serial_add_sched.sv
// Round-robin scheduler/sequencer for a shared bit-serial adder (two requesters).
// Define SA_SUB_EN to add per-requester subtract (a - b, sum[WIDTH] = no-borrow).
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               resetn,
  serial_add_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             gnt, gnt_arb, sub_v, done_o;
  logic                   rr, c, c_nxt, bit_s, gidx, last, busy_o;
  logic [WIDTH-1:0]       sa, sb, s;
  logic [CW-1:0]          cnt;
  logic [WIDTH:0]         sum;
  logic [1:0][WIDTH-1:0]  opa, opb;

  assign opa = {bus.a1, bus.a0};
  assign opb = {bus.b1, bus.b0};
`ifdef SA_SUB_EN
  assign sub_v = bus.sub;
`else
  assign sub_v = 2'b00;
`endif

  assign gidx  = gnt[1];
  assign last  = (cnt == CW'(WIDTH - 1));
  assign bit_s = sa[0] ^ sb[0] ^ c;
  assign c_nxt = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);

  // rr names the requester that wins a tie
  always_comb begin
    gnt_arb = 2'b00;
    case (bus.req)
      2'b01:   gnt_arb = 2'b01;
      2'b10:   gnt_arb = 2'b10;
      2'b11:   gnt_arb = rr ? 2'b10 : 2'b01;
      default: gnt_arb = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE) ? gnt : 2'b00;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt <= '0;
      rr  <= 1'b0;
      sa  <= '0;
      sb  <= '0;
      s   <= '0;
      c   <= 1'b0;
      cnt <= '0;
      sum <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          gnt <= gnt_arb;
          rr  <= gnt_arb[0];
        end
        LOAD: begin
          // subtract is a + ~b + 1: invert b and preset the carry
          sa  <= opa[gidx];
          sb  <= sub_v[gidx] ? ~opb[gidx] : opb[gidx];
          c   <= sub_v[gidx];
          cnt <= '0;
          s   <= '0;
        end
        SHIFT: begin
          c   <= c_nxt;
          s   <= {bit_s, s[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          // result captured with the final bit so it is valid throughout DONE
          if (last) sum <= {c_nxt, bit_s, s[WIDTH-1:1]};
        end
        DONE: gnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.gnt  = gnt;
  assign bus.done = done_o;
  assign bus.sum  = sum;
  assign bus.busy = busy_o;
endmodule
